vec_mac_accumulator: RTL and testbench



---
 rtl/accel_pkg.sv | 13 +
 rtl/vec_mac_accumulator.sv | 146 ++++++++++++++
 tb/tb_vec_mac_accumulator.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accel_pkg.sv
// Shared types and widths for the accelerator datapath stages.
package accel_pkg;

    localparam int OPERAND_WIDTH = 16;
    localparam int PRODUCT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

endpackage

// File: rtl/vec_mac_accumulator.sv
// Streaming signed dot-product stage: one packed (a,b) word per accept,
// products summed over vec_len elements, result offered on a valid/ready port.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for the first element of a vector
// ACCUM  | summing elements, waiting for the remaining words
// OUTPUT | result held on out_data until the writeback stage takes it
module vec_mac_accumulator #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 48,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LEN_WIDTH-1:0]  vec_len,
    input  logic                  flush,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);
    import accel_pkg::*;

    state_t                         r_state;
    state_t                         w_state_next;
    logic        [ACC_WIDTH-1:0]    r_acc;
    logic        [ACC_WIDTH-1:0]    w_acc_next;
    logic        [LEN_WIDTH:0]      r_elem_cnt;
    logic        [LEN_WIDTH:0]      w_elem_cnt_next;
    logic        [LEN_WIDTH-1:0]    r_len_q;
    logic        [LEN_WIDTH-1:0]    w_len_next;
    logic        [ACC_WIDTH-1:0]    r_out_data;
    logic        [ACC_WIDTH-1:0]    w_out_data_next;
    logic                           r_out_valid;
    logic                           w_out_valid_next;

    logic signed [OPERAND_WIDTH-1:0] w_a;
    logic signed [OPERAND_WIDTH-1:0] w_b;
    logic signed [PRODUCT_WIDTH-1:0] w_product;
    logic        [ACC_WIDTH-1:0]     w_product_ext;
    logic        [ACC_WIDTH-1:0]     w_acc_sum;
    logic        [LEN_WIDTH:0]       w_elem_cnt_inc;
    logic        [LEN_WIDTH-1:0]     w_len_eff;
    logic                            w_accept;

    assign w_a            = in_data[31:16];
    assign w_b            = in_data[15:0];
    assign w_product      = PRODUCT_WIDTH'(w_a) * PRODUCT_WIDTH'(w_b);
    assign w_product_ext  = {{(ACC_WIDTH-PRODUCT_WIDTH){w_product[PRODUCT_WIDTH-1]}}, w_product};
    assign w_acc_sum      = r_acc + w_product_ext;
    assign w_elem_cnt_inc = r_elem_cnt + {{LEN_WIDTH{1'b0}}, 1'b1};
    // A zero length is treated as a single-element vector.
    assign w_len_eff      = (vec_len == '0) ? {{(LEN_WIDTH-1){1'b0}}, 1'b1} : vec_len;

    // in_ready depends only on state and flush, never on in_valid/out_ready.
    assign in_ready  = (r_state != OUTPUT) && !flush;
    assign w_accept  = in_valid && in_ready;
    assign busy      = (r_state != IDLE);
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

    // Next-state and datapath update; flush overrides everything else.
    always_comb begin
        w_state_next     = r_state;
        w_acc_next       = r_acc;
        w_elem_cnt_next  = r_elem_cnt;
        w_len_next       = r_len_q;
        w_out_data_next  = r_out_data;
        w_out_valid_next = r_out_valid;
        if (flush) begin
            w_state_next     = IDLE;
            w_out_valid_next = 1'b0;
            w_acc_next       = '0;
            w_elem_cnt_next  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        w_len_next      = w_len_eff;
                        w_acc_next      = w_product_ext;
                        w_elem_cnt_next = {{LEN_WIDTH{1'b0}}, 1'b1};
                        if (w_len_eff == {{(LEN_WIDTH-1){1'b0}}, 1'b1}) begin
                            w_state_next     = OUTPUT;
                            w_out_data_next  = w_product_ext;
                            w_out_valid_next = 1'b1;
                        end else begin
                            w_state_next = ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        w_acc_next      = w_acc_sum;
                        w_elem_cnt_next = w_elem_cnt_inc;
                        if (w_elem_cnt_inc == {1'b0, r_len_q}) begin
                            w_state_next     = OUTPUT;
                            w_out_data_next  = w_acc_sum;
                            w_out_valid_next = 1'b1;
                        end
                    end
                end
                OUTPUT: begin
                    if (r_out_valid && out_ready) begin
                        w_state_next     = IDLE;
                        w_out_valid_next = 1'b0;
                    end
                end
                default: begin
                    w_state_next     = IDLE;
                    w_out_valid_next = 1'b0;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Accumulator, counters and registered result port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc       <= '0;
            r_elem_cnt  <= '0;
            r_len_q     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_acc       <= w_acc_next;
            r_elem_cnt  <= w_elem_cnt_next;
            r_len_q     <= w_len_next;
            r_out_data  <= w_out_data_next;
            r_out_valid <= w_out_valid_next;
        end
    end

endmodule

// File: tb/tb_vec_mac_accumulator.sv
// Self-checking bench for vec_mac_accumulator. Inputs change and outputs are
// sampled on the falling edge; expected sums are queued as vectors are sent.
module tb_vec_mac_accumulator;

    logic        clock;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  vec_len;
    logic        flush;
    logic [47:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int          n_checks;
    int          n_fail;
    logic [47:0] exp_q[$];

    vec_mac_accumulator #(.DATA_WIDTH(32), .ACC_WIDTH(48), .LEN_WIDTH(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .vec_len  (vec_len),
        .flush    (flush),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] pk(input int a, input int b);
        logic [31:0] r;
        r = {a[15:0], b[15:0]};
        return r;
    endfunction

    // Offer one word (after optional random idle gap) until it is accepted.
    task automatic send_word(input logic [31:0] w, input int gap_max);
        int gaps;
        int t;
        gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        for (int i = 0; i < gaps; i++) begin
            in_valid = 1'b0;
            in_data  = $urandom;
            @(negedge clock);
        end
        in_valid = 1'b1;
        in_data  = w;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (t >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_word: in_ready never rose, actual in_ready=%0b required 1", in_ready);
        end
        @(negedge clock);
    endtask

    // Send a whole vector; vec_len is scrambled after the first accept.
    task automatic send_vector(input int len_field, input logic [31:0] words[$], input int gap_max);
        vec_len = len_field[7:0];
        for (int i = 0; i < words.size(); i++) begin
            send_word(words[i], gap_max);
            if (i == 0) vec_len = 8'($urandom_range(255, 0));
        end
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic wait_result(output logic [47:0] d, output logic seen);
        int t;
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clock);
            t++;
        end
        seen = out_valid;
        d    = out_data;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; vec_len = '0; flush = 1'b0; out_ready = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid actual=%0b required=0", out_valid); end
        n_checks++; if (out_data !== 48'h0) begin n_fail++; $display("FAIL reset_out_data actual=%h required=0", out_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy actual=%0b required=0", busy); end
        @(negedge clock); @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready actual=%0b required=1", in_ready); end
    endtask

    task automatic test_basic;
        logic [31:0] wq[$];
        logic [47:0] exp;
        wq.push_back(pk(2, 3)); wq.push_back(pk(-4, 5)); wq.push_back(pk(1, 1));
        exp_q.push_back(48'hFFFF_FFFF_FFF3);
        send_vector(3, wq, 0);
        exp = exp_q.pop_front();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency out_valid actual=%0b required=1", out_valid); end
        n_checks++; if (out_data !== exp) begin n_fail++; $display("FAIL basic_data actual=%h required=%h", out_data, exp); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_bubble in_ready actual=%0b required=0", in_ready); end
        @(negedge clock);
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_release valid/busy actual=%0b/%0b required=0/0", out_valid, busy); end
    endtask

    task automatic test_len_edges;
        logic [31:0] wq[$];
        logic [47:0] d;
        logic        seen;
        int          lens[2];
        lens[0] = 1; lens[1] = 0;
        foreach (lens[k]) begin
            wq = {};
            wq.push_back(pk(7, -2));
            exp_q.push_back(48'hFFFF_FFFF_FFF2);
            send_vector(lens[k], wq, 0);
            wait_result(d, seen);
            n_checks++;
            if (!seen || d !== exp_q[0]) begin n_fail++; $display("FAIL len%0d_data actual=%h valid=%0b required=%h", lens[k], d, seen, exp_q[0]); end
            void'(exp_q.pop_front());
            @(negedge clock);
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL len%0d_idle busy actual=%0b required=0", lens[k], busy); end
        end
        wq = {};
        for (int i = 0; i < 255; i++) wq.push_back(32'h8000_8000);
        exp_q.push_back(48'h003F_C000_0000);
        send_vector(255, wq, 0);
        wait_result(d, seen);
        n_checks++;
        if (!seen || d !== exp_q[0]) begin n_fail++; $display("FAIL len255_data actual=%h valid=%0b required=%h", d, seen, exp_q[0]); end
        void'(exp_q.pop_front());
        @(negedge clock);
    endtask

    task automatic test_backpressure;
        logic [31:0] wq[$];
        logic [47:0] exp;
        logic [47:0] d;
        logic        seen;
        int          bad;
        out_ready = 1'b0;
        wq.push_back(pk(2, 3)); wq.push_back(pk(-4, 5)); wq.push_back(pk(1, 1));
        exp_q.push_back(48'hFFFF_FFFF_FFF3);
        send_vector(3, wq, 0);
        exp = exp_q.pop_front();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== exp) bad++;
            @(negedge clock);
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold bad_cycles actual=%0d required=0 (data=%h exp=%h)", bad, out_data, exp); end
        n_checks++; if (out_valid !== 1'b1 || out_data !== exp) begin n_fail++; $display("FAIL bp_still_valid actual=%0b/%h required=1/%h", out_valid, out_data, exp); end
        out_ready = 1'b1;
        @(negedge clock);
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_release valid/busy actual=%0b/%0b required=0/0", out_valid, busy); end
        wq = {};
        wq.push_back(pk(1, 1)); wq.push_back(pk(1, 1));
        exp_q.push_back(48'd2);
        send_vector(2, wq, 0);
        wait_result(d, seen);
        n_checks++;
        if (!seen || d !== exp_q[0]) begin n_fail++; $display("FAIL bp_next_data actual=%h valid=%0b required=%h", d, seen, exp_q[0]); end
        void'(exp_q.pop_front());
        @(negedge clock);
    endtask

    task automatic test_gaps;
        logic [31:0] wq[$];
        logic [47:0] d;
        logic        seen;
        wq.push_back(pk(2, 3)); wq.push_back(pk(-4, 5)); wq.push_back(pk(1, 1));
        for (int r = 0; r < 3; r++) begin
            exp_q.push_back(48'hFFFF_FFFF_FFF3);
            send_vector(3, wq, 4);
            wait_result(d, seen);
            n_checks++;
            if (!seen || d !== exp_q[0]) begin n_fail++; $display("FAIL gaps_%0d_data actual=%h valid=%0b required=%h", r, d, seen, exp_q[0]); end
            void'(exp_q.pop_front());
            @(negedge clock);
        end
    endtask

    task automatic test_flush;
        logic [31:0] wq[$];
        logic [47:0] d;
        logic        seen;
        int          pulses;
        vec_len = 8'd4;
        send_word(pk(2, 2), 0);
        send_word(pk(2, 2), 0);
        in_valid = 1'b1; in_data = pk(5, 5); flush = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready actual=%0b required=0", in_ready); end
        @(negedge clock);
        flush = 1'b0; in_valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid !== 1'b0) pulses++;
            @(negedge clock);
        end
        n_checks++; if (pulses != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_no_result pulses=%0d busy=%0b required 0/0", pulses, busy); end
        wq.push_back(pk(3, 3)); wq.push_back(pk(1, -1));
        exp_q.push_back(48'd8);
        send_vector(2, wq, 0);
        wait_result(d, seen);
        n_checks++;
        if (!seen || d !== exp_q[0]) begin n_fail++; $display("FAIL flush_next_data actual=%h valid=%0b required=%h", d, seen, exp_q[0]); end
        void'(exp_q.pop_front());
        @(negedge clock);
    endtask

    task automatic test_flush_output;
        logic [31:0] wq[$];
        int          pulses;
        out_ready = 1'b0;
        wq.push_back(pk(7, -2));
        send_vector(1, wq, 0);
        n_checks++; if (out_valid !== 1'b1 || out_data !== 48'hFFFF_FFFF_FFF2) begin n_fail++; $display("FAIL flush_out_pre actual=%0b/%h required=1/fffffffffff2", out_valid, out_data); end
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        out_ready = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid !== 1'b0) pulses++;
            @(negedge clock);
        end
        n_checks++; if (pulses != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_out_drop pulses=%0d busy=%0b required 0/0", pulses, busy); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] wq[$];
        logic [47:0] d;
        logic        seen;
        vec_len = 8'd4;
        send_word(pk(100, 100), 0);
        send_word(pk(100, 100), 0);
        in_valid = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy_pre actual=%0b required=1", busy); end
        reset = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 48'h0) begin n_fail++; $display("FAIL rst_mid_outputs busy/valid/data actual=%0b/%0b/%h required=0/0/0", busy, out_valid, out_data); end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        out_ready = 1'b0;
        wq.push_back(pk(-3, 4));
        send_vector(1, wq, 0);
        reset = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_data !== 48'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_output valid/data/busy actual=%0b/%h/%0b required=0/0/0", out_valid, out_data, busy); end
        @(negedge clock);
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        wq = {};
        wq.push_back(pk(3, 3)); wq.push_back(pk(1, -1));
        exp_q.push_back(48'd8);
        send_vector(2, wq, 0);
        wait_result(d, seen);
        n_checks++;
        if (!seen || d !== exp_q[0]) begin n_fail++; $display("FAIL rst_next_data actual=%h valid=%0b required=%h", d, seen, exp_q[0]); end
        void'(exp_q.pop_front());
        @(negedge clock);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_len_edges();
        test_backpressure();
        test_gaps();
        test_flush();
        test_flush_output();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
